// File: rtl/divider_seq.sv
// divider_seq: sequential unsigned divider (restoring shift-subtract),
// producing one quotient bit per clock beside the combinational ALU.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset
//   dataA    - dividend, sampled on the start edge only
//   dataB    - divisor, sampled on the start edge only
//   Signal   - function code; only DIVU starts a division
//   dataOut  - {remainder, quotient} (HI/LO layout), held until next completion
//   busy     - high while the division steps are running
//   done     - one-cycle pulse right after dataOut is updated
//   div_zero - latched divisor was zero; updated together with dataOut
module divider_seq #(
  parameter int          WIDTH = 32,
  parameter logic [5:0]  DIVU  = 6'b011011
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     dataA,
  input  logic [WIDTH-1:0]     dataB,
  input  logic [5:0]           Signal,
  output logic [2*WIDTH-1:0]   dataOut,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quot_q, quot_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [2*WIDTH-1:0]   dout_q, dout_d;
  logic                 dz_q, dz_d;

  logic                 start;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     rem_nx, quot_nx;

  assign start = (Signal == DIVU);

  // Partial remainder always stays below the divisor, so WIDTH bits hold it;
  // the extra trial bit keeps the shifted-out MSB when the divisor's MSB is set.
  assign trial   = {rem_q, quot_q[WIDTH-1]} - {1'b0, dvs_q};
  assign rem_nx  = trial[WIDTH] ? {rem_q[WIDTH-2:0], quot_q[WIDTH-1]} : trial[WIDTH-1:0];
  assign quot_nx = {quot_q[WIDTH-2:0], ~trial[WIDTH]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      dout_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      dout_q  <= dout_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    dout_d  = dout_q;
    dz_d    = dz_q;
    case (state_q)
      // DONE accepts a new start exactly like IDLE, allowing back-to-back ops.
      IDLE, DONE: begin
        if (start) begin
          rem_d   = '0;
          quot_d  = dataA;
          dvs_d   = dataB;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        rem_d  = rem_nx;
        quot_d = quot_nx;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          dout_d  = {rem_nx, quot_nx};
          dz_d    = (dvs_q == '0);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign dataOut  = dout_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_divider_seq.sv
module tb_divider_seq;

  localparam logic [5:0] DIVU = 6'b011011;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dataA = '0, dataB = '0;
  logic [5:0]  Signal = '0;
  logic [63:0] dataOut;
  logic        busy, done, div_zero;

  divider_seq dut (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .Signal(Signal),
    .dataOut(dataOut), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] out;
    logic        dz;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0, n_err = 0;
  int          cyc = 0;
  logic [63:0] last_out = '0;
  logic        last_dz = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned division; divide by zero yields all-ones
  // quotient and the dividend as remainder.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.out = model(a, b);
    e.dz  = (b == 0);
    e.due = cyc + 32;
    sb.push_back(e);
    last_out = e.out;
    last_dz  = e.dz;
  endtask

  // Inputs change 1ns after a rising edge; start is taken at the next edge.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    Signal = DIVU; dataA = a; dataB = b;
    @(posedge clk); #1;
    push_exp(a, b);
    Signal = 6'd0; dataA = $urandom; dataB = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // Monitor: compare every done pulse against the scoreboard head.
  int   busy_run = 0;
  logic prev_done = 1'b0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      busy_run = 0; prev_done = 1'b0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        chk("single_done_pulse", {63'd0, prev_done}, 64'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("dataOut", dataOut, e.out);
          chk("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
          chk("latency", 64'(cyc), 64'(e.due));
          chk("busy_cycles", 64'(busy_run), 64'd32);
        end
        busy_run = 0;
      end
      prev_done = done;
    end
  end

  initial begin
    logic [31:0] a, b;
    // Reset state
    #12;
    chk("rst_dataOut", dataOut, 64'd0);
    chk("rst_flags", {61'd0, busy, done, div_zero}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: 100/7
    start(32'd100, 32'd7);
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    drain();
    chk("t1_result", dataOut, 64'h00000002_0000000E);

    // 2: max operands
    start(32'hFFFF_FFFF, 32'h8000_0000); drain();
    chk("t2a_result", dataOut, 64'h7FFFFFFF_00000001);
    start(32'hFFFF_FFFF, 32'd1); drain();
    chk("t2b_result", dataOut, 64'h00000000_FFFFFFFF);

    // 3: divide by zero, then a normal op clears div_zero
    start(32'd5, 32'd0); drain();
    chk("t3_dz_result", dataOut, 64'h00000005_FFFFFFFF);
    chk("t3_dz_flag", {63'd0, div_zero}, 64'd1);
    start(32'd9, 32'd3); drain();
    chk("t3_clear", {div_zero, dataOut[62:0]}, {1'b0, 63'h00000000_00000003});

    // 4: interference mid-run; DIVU present at DONE starts a second op
    start(32'd1000, 32'd10);
    for (int i = 1; i <= 32; i++) begin
      Signal = DIVU; dataA = $urandom; dataB = $urandom;
      @(posedge clk); #1;
    end
    chk("t4_done_state", {62'd0, busy, done}, 64'd1);
    chk("t4_first", dataOut, 64'h00000000_00000064);
    Signal = DIVU; dataA = 32'd77777; dataB = 32'd123;
    @(posedge clk); #1;
    push_exp(32'd77777, 32'd123);
    Signal = 6'd0;
    chk("t4_restart_busy", {63'd0, busy}, 64'd1);
    drain();

    // 5: reset mid-operation
    start(32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("t5_async_clear", dataOut, 64'd0);
    chk("t5_async_flags", {61'd0, busy, done, div_zero}, 64'd0);
    sb.delete();
    last_out = '0; last_dz = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("t5_no_done", {62'd0, busy, done}, 64'd0);
    start(32'd50, 32'd6); drain();
    chk("t5_after", dataOut, 64'h00000002_00000008);

    // 6: other function codes are ignored
    Signal = 6'b100000; dataA = 32'd1; dataB = 32'd1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_add_flags", {62'd0, busy, done}, 64'd0);
    Signal = 6'b000000;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_hold", dataOut, last_out);

    // Random operations
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 15));
        1: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      start(a, b);
      drain();
      chk("rnd_hold", {dataOut, 63'd0, div_zero}, {last_out, 63'd0, last_dz});
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
- Sequential 32-bit unsigned divider (DIVU) that sits beside the combinational ALU in the datapath.
- Driven by the same 6-bit function code on `Signal`.
- Uses a restoring shift-subtract algorithm, one quotient bit per clock.
- Produces a 64-bit `{remainder, quotient}` result in HI/LO layout. A `busy`/`done` handshake lets the controller stall while it waits.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH.
- DIVU, 6'b011011, function code that starts a division.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- dataA  input  32  dividend; sampled only on the start edge.
- dataB  input  32  divisor; sampled only on the start edge.
- Signal  input  6  function code; only DIVU has an effect, all other codes are ignored.
- dataOut  output  64  bits [63:32] are the remainder (HI), bits [31:0] are the quotient (LO).
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when dataOut has just been updated.
- div_zero  output  1  set when the latched divisor was 0; updated together with dataOut.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and the step counter to 0.
  - Internal rem/quot/divisor registers clear to 0.
  - dataOut=0, busy=0, done=0, div_zero=0.
  - A reset during RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - If Signal==DIVU at a rising edge, latch the operands: R=33'b0, Q=dataA, D=dataB. Then set count=0 and go to RUN.
  - Otherwise stay in IDLE.
- RUN, one step per edge:
  - T = {R[31:0], Q[31]} - {1'b0, D} (33-bit subtract).
  - If T[32]==0: R=T, Q={Q[30:0],1}. Otherwise: R={R[31:0],Q[31]}, Q={Q[30:0],0}.
  - count increments each step.
  - On the step with count==31, also write dataOut={R_next[31:0], Q_next}, write div_zero=(D==0), and go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - Next edge: if Signal==DIVU, start a new division exactly as from IDLE (back-to-back); otherwise go to IDLE.
- Outputs:
  - busy=1 iff state==RUN; done=1 iff state==DONE. Both are decoded from registered state.
- Latency:
  - Start accepted at edge k; steps occur at edges k+1..k+32.
  - dataOut is valid and done is high after edge k+32, i.e. 32 cycles after start.
- Hold behaviour:
  - dataOut and div_zero hold their value until the next completion or a reset.
  - They are not cleared at the start of a new operation.
- Signal during RUN is ignored, including DIVU; dataA/dataB changes during RUN are ignored.
- Divide by zero:
  - There is no special path; the algorithm naturally yields quotient=32'hFFFFFFFF and remainder=dividend. div_zero=1.
  - Latency is unchanged.
- Arithmetic is unsigned throughout:
  - The 33-bit subtract prevents loss of the shifted-out bit when the divisor's MSB is 1.
  - No overflow case exists.

Test Plan:
1. Reset then 100/7: drive reset low then high, Signal=DIVU, dataA=100, dataB=7 for one cycle. Expected:
   - busy=1 for 32 cycles.
   - done pulses for exactly 1 cycle.
   - dataOut=64'h00000002_0000000E, div_zero=0.
2. Max operands: dataA=32'hFFFFFFFF, dataB=32'h80000000 → dataOut=64'h7FFFFFFF_00000001. Then dataA=32'hFFFFFFFF, dataB=1 → dataOut=64'h00000000_FFFFFFFF.
3. Divide by zero: dataA=5, dataB=0 → dataOut=64'h00000005_FFFFFFFF, div_zero=1, latency 32. A following 9/3 clears div_zero=0 and gives dataOut=64'h00000000_00000003.
4. Interference during RUN: start 1000/10, then toggle dataA/dataB and hold Signal=DIVU mid-RUN. Expected:
   - No restart.
   - dataOut=64'h00000000_00000064 at the expected edge.
   - A second division starts from DONE only because DIVU is present there.
5. Mid-operation reset: start 100/7, assert reset at step 10. Expected:
   - Outputs clear immediately without waiting for an edge.
   - No done pulse.
   - After release, a new 50/6 yields dataOut=64'h00000002_00000008.
6. Other function codes: Signal=ADD (6'b100000) or 6'b000000 while IDLE → busy stays 0, done stays 0, dataOut holds its prior value.
